// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM states, baud divider math and vote helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    function automatic int calc_div(input int clock_freq, input int baud_rate, input int oversample);
        return clock_freq / (baud_rate * oversample);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk tick every DIV clks, restartable by a synchronous clear.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic tick_o
);

    localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    generate
        if (DIV < 1) begin : g_err_div
            $error("uart_baud_tick: DIV must be >= 1");
        end
    endgenerate

    always_comb begin
        // NOTE: every output of a combinational block gets a value first, so no path can infer a latch.
        cnt_d  = cnt_q + CW'(1);
        tick_o = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            tick_o = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking (<=) in clocked blocks so every flop samples pre-edge values.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampled, majority-voted UART receiver with valid/ready output register and error flags.
// Optional break detection when UART_RX_BREAK_DETECT_EN is defined (adds break_det port).
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 1_843_200,
    parameter int BAUD_RATE  = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 data_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 overrun_error
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    output logic                 break_det
`endif
);

    localparam int DIV = calc_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [SW-1:0] S_VOTE_A  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_VOTE_B  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_DECIDE  = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    generate
        if (DIV < 1) begin : g_err_div
            $error("uart_rx_param: CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE) must be >= 1");
        end
        if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_err_os
            $error("uart_rx_param: OVERSAMPLE must be even and >= 8");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_db
            $error("uart_rx_param: DATA_BITS must be 5..9");
        end
        if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_err_par
            $error("uart_rx_param: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_stop
            $error("uart_rx_param: STOP_BITS must be 1 or 2");
        end
    endgenerate

    logic [1:0]           sync_q;
    logic                 rx_prev_q;
    logic                 rx_s;
    logic                 tick;
    logic                 div_clear;

    rx_state_e            state_q, state_d;
    logic [SW-1:0]        s_q, s_d;
    logic [1:0]           samp_q, samp_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    logic                 vote;
    logic                 decide;
    logic                 bit_end;
    logic                 start_edge;
    logic                 done;
    logic                 push;
    logic                 is_break;
    logic                 brk_block;
    logic                 par_expect;

    // Synchroniser resets to the idle level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], data_in};
            rx_prev_q <= sync_q[1];
        end
    end

    assign rx_s = sync_q[1];

    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (div_clear),
        .tick_o  (tick)
    );

    assign vote       = maj3(samp_q[0], samp_q[1], rx_s);
    assign decide     = tick && (s_q == S_DECIDE);
    assign bit_end    = tick && (s_q == S_LAST);
    assign start_edge = rx_prev_q && !rx_s && !brk_block;
    assign par_expect = (PARITY == PARITY_ODD) ? ~(^shift_q) : (^shift_q);

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        samp_d     = samp_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        div_clear  = 1'b0;
        done       = 1'b0;

        if (state_q != ST_IDLE && tick) begin
            s_d = (s_q == S_LAST) ? '0 : s_q + SW'(1);
            if (s_q == S_VOTE_A) samp_d[0] = rx_s;
            if (s_q == S_VOTE_B) samp_d[1] = rx_s;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d   = ST_START;
                    s_d       = '0;
                    div_clear = 1'b1;
                    par_err_d = 1'b0;
                    frm_err_d = 1'b0;
                end
            end
            ST_START: begin
                if (decide && vote) begin
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (decide) shift_d = {vote, shift_q[DATA_BITS-1:1]};
                if (bit_end) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d    = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (decide) par_err_d = (vote != par_expect);
                if (bit_end) begin
                    state_d    = ST_STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            ST_STOP: begin
                if (decide) begin
                    frm_err_d = frm_err_q | ~vote;
                    if (stop_cnt_q == STOP_LAST) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (bit_end) begin
                    stop_cnt_d = ~stop_cnt_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            samp_q     <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            samp_q     <= samp_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    logic saw_one_q, saw_one_d;
    logic brk_q, brk_d;

    // A break is a frame whose every vote, start through last stop, came out 0.
    assign is_break  = done && !saw_one_q && !vote;
    assign brk_block = brk_q;
    assign break_det = brk_q;

    always_comb begin
        saw_one_d = saw_one_q;
        brk_d     = brk_q;
        if (state_q == ST_IDLE) begin
            if (start_edge) saw_one_d = 1'b0;
        end else if (decide) begin
            saw_one_d = saw_one_q | vote;
        end
        if (is_break) begin
            brk_d = 1'b1;
        end else if (rx_s) begin
            brk_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            saw_one_q <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            saw_one_q <= saw_one_d;
            brk_q     <= brk_d;
        end
    end
`else
    assign is_break  = 1'b0;
    assign brk_block = 1'b0;
`endif

    assign push = done && !is_break;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = 1'b0;
        if (push && (!valid_q || rx_ready)) begin
            data_d  = shift_q;
            perr_d  = par_err_q;
            ferr_d  = frm_err_q | ~vote;
            valid_d = 1'b1;
        end else if (push) begin
            ovr_d = 1'b1;
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign parity_error  = perr_q;
    assign frame_error   = ferr_q;
    assign overrun_error = ovr_q;

endmodule
